// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient feeds LO, remainder HI.
// One trial subtract per cycle, MSB first, signs applied after the loop.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        FIXUP,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // dvd doubles as the quotient register: bits shift in at the LSB
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sgn         <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        sgn   <= is_signed;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dvd   <= (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
                    dvs   <= (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
                    q_neg <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    r_neg <= sgn & a_q[WIDTH-1];
                    rem   <= '0;
                    cnt   <= '0;
                    state <= (b_q == '0) ? FIXUP : DIVIDE;
                end
                DIVIDE: begin
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0]
                                        : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIXUP: begin
                    if (b_q == '0) begin
                        quotient    <= '1;
                        remainder   <= a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? -dvd : dvd;
                        remainder   <= r_neg ? -rem : rem;
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed vector table, multi-cycle corner sequences and a random
// sweep checked against a behavioural 64-bit divide model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int ncmp = 0;
    int nerr = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; leaves us at the negedge where done is seen.
    task automatic run_op(input bit sg, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~sg;
        dividend  = $urandom;
        divisor   = $urandom;
        lat = 1;
        chk("busy_c1", {31'b0, busy}, 32'd1);
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic end_op(input string tag, input int lat,
                          input logic [31:0] eq, input logic [31:0] er,
                          input bit edz, input int elat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_q_held"}, quotient, eq);
    endtask

    function automatic void model(input bit sg, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output bit dz);
        longint sa;
        longint sb;
        dz = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int          lat;
        int          nd;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          edz;
        bit          sg;

        tv[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35};
        tv[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD,
                   32'hFFFFFFFF, 1'b0, 35};
        tv[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                   32'd0, 1'b0, 35};
        tv[3]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                   32'd0, 1'b0, 35};
        tv[4]  = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 3};
        tv[5]  = '{1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 35};
        tv[6]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD,
                   32'd1, 1'b0, 35};
        tv[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,
                   32'hFFFFFFFF, 1'b0, 35};
        tv[8]  = '{1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF,
                   32'hFFFFFFF9, 1'b1, 3};
        tv[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,
                   32'h80000000, 1'b0, 35};
        tv[10] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 35};
        tv[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                   32'd0, 1'b0, 35};
        tv[12] = '{1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // back-to-back: end_op returns in the IDLE cycle after done
        for (int i = 0; i < 13; i++) begin
            run_op(tv[i].sg, tv[i].a, tv[i].b, lat);
            end_op($sformatf("vec%0d", i), lat, tv[i].q, tv[i].r,
                   tv[i].dz, tv[i].lat);
        end

        // start mid-operation and during DONE must be dropped, not queued
        start = 1'b1; is_signed = 1'b0; dividend = 9; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge clk);
        chk("mid_q_stable", quotient, 32'd14);
        start = 1'b1; dividend = 100; divisor = 7;
        @(negedge clk);
        start = 1'b0;
        lat = 11;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("ign_lat", lat, 35);
        chk("ign_q", quotient, 32'd3);
        chk("ign_r", remainder, 32'd0);
        start = 1'b1; dividend = 100; divisor = 7;
        @(negedge clk);
        start = 1'b0;
        count_dones(45, nd);
        chk("ign_no_queue", nd, 0);

        // reset in flight: no done, outputs cleared
        start = 1'b1; dividend = 9; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge clk);
        start = 1'b1; dividend = 100; divisor = 7;
        @(negedge clk);
        start = 1'b0;
        for (int c = 12; c <= 20; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("fl_rst_busy", {31'b0, busy}, 32'd0);
        chk("fl_rst_done", {31'b0, done}, 32'd0);
        chk("fl_rst_q", quotient, 32'd0);
        chk("fl_rst_r", remainder, 32'd0);
        reset = 1'b0;
        count_dones(45, nd);
        chk("fl_no_done", nd, 0);
        run_op(1'b0, 32'd9, 32'd3, lat);
        end_op("post_rst", lat, 32'd3, 32'd0, 1'b0, 35);

        for (int n = 0; n < 300; n++) begin
            sg = $urandom_range(0, 1);
            ea = $urandom;
            case ($urandom_range(0, 4))
                0: eb = $urandom;
                1: eb = $urandom_range(1, 15);
                2: eb = $urandom >> $urandom_range(1, 30);
                3: eb = -($urandom_range(1, 15));
                default: eb = (n % 25 == 0) ? 32'd0 : $urandom_range(1, 999);
            endcase
            if ($urandom_range(0, 3) == 0) ea = ea >> $urandom_range(0, 31);
            model(sg, ea, eb, eq, er, edz);
            run_op(sg, ea, eb, lat);
            end_op($sformatf("rnd%0d", n), lat, eq, er, edz, edz ? 3 : 35);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
